// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_txn_arbiter_pkg;

  // FSM state encoding, 3 bits.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_CAPT    = 3'd4
  } arb_state_t;

  // Default frame width, matches the SPI_MASTER build (`m = 9).
  localparam int FRAME_W = 9;

  // Bits needed to hold an index in 0..n-1; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr,
// wrapping modulo N. Output is one-hot; any flags a valid pick.
module spi_txn_arbiter_rr_pick
  import spi_txn_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          pick,
  output logic                  any
);

  localparam int PW = idx_w(N);

  logic [PW:0] pos;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    pos  = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!any && req[pos[PW-1:0]]) begin
        pick[pos[PW-1:0]] = 1'b1;
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI_MASTER between N requesters, one
// frame per grant. Drives st/MTX_DAT, detects frame end from LOAD, returns
// MRX_DAT with a one-cycle done pulse.
// Optional watchdog on the LOAD phases: define SPI_ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a request while the master reports idle (load=1)
// S_START   | st held high for ST_LEN cycles
// S_WAIT_LO | waiting for the master to pull load low (frame running)
// S_WAIT_HI | waiting for load to return high (frame end)
// S_CAPT    | rx_dat captured, done pulsing; grant released on exit
module spi_txn_arbiter
  import spi_txn_arbiter_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = FRAME_W,
  parameter int ST_LEN = 3,
  parameter int TO_CYC = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] tx_dat,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   rx_dat,
  output logic           busy,
  output logic [N-1:0]   err,
  output logic           st,
  output logic [W-1:0]   mtx_dat,
  input  logic           load,
  input  logic [W-1:0]   mrx_dat
);

  localparam int PW = idx_w(N);
  localparam int SW = idx_w(ST_LEN) + 1;
  localparam logic [SW-1:0] ST_LOAD = SW'(ST_LEN - 1);

  arb_state_t    state_q, state_n;
  logic          load_s1, load_s2;
  logic [N-1:0]  gnt_q, gnt_n;
  logic [N-1:0]  done_q, done_n;
  logic [N-1:0]  err_q, err_n;
  logic [N-1:0]  pick;
  logic          any;
  logic [PW-1:0] gnt_idx_q, gnt_idx_n;
  logic [PW-1:0] rr_ptr_q, rr_ptr_n;
  logic [PW-1:0] pick_idx, ptr_adv;
  logic [W-1:0]  mtx_q, mtx_n;
  logic [W-1:0]  rx_q, rx_n;
  logic [W-1:0]  tx_sel;
  logic [SW-1:0] st_cnt_q, st_cnt_n;
  logic          to_expire;

  spi_txn_arbiter_rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .any  (any)
  );

  // Two-flop synchroniser for the master's LOAD; clears to 0 so that after
  // reset no grant happens until load is actually seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_s1 <= 1'b0;
      load_s2 <= 1'b0;
    end else begin
      load_s1 <= load;
      load_s2 <= load_s1;
    end
  end

  // Encode the one-hot pick and select the matching payload slice.
  always_comb begin
    pick_idx = '0;
    tx_sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
        tx_sel   = tx_dat[i*W +: W];
      end
    end
  end

  assign ptr_adv = (gnt_idx_q == PW'(N - 1)) ? '0 : gnt_idx_q + PW'(1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = idx_w(TO_CYC) + 1;
  localparam logic [TW-1:0] TO_LOAD = TW'(TO_CYC - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_n;

  // Watchdog down-counter, reloaded on entry to each LOAD-phase state.
  always_comb begin
    to_cnt_n = to_cnt_q;
    case (state_q)
      S_START:   to_cnt_n = TO_LOAD;
      S_WAIT_LO: begin
        if (!load_s2)              to_cnt_n = TO_LOAD;
        else if (to_cnt_q != '0)   to_cnt_n = to_cnt_q - TW'(1);
      end
      S_WAIT_HI: begin
        if (to_cnt_q != '0)        to_cnt_n = to_cnt_q - TW'(1);
      end
      default:   to_cnt_n = to_cnt_q;
    endcase
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_n;
  end

  assign to_expire = (to_cnt_q == '0);
`else
  assign to_expire = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    gnt_n     = gnt_q;
    gnt_idx_n = gnt_idx_q;
    rr_ptr_n  = rr_ptr_q;
    done_n    = '0;
    err_n     = '0;
    rx_n      = rx_q;
    mtx_n     = mtx_q;
    st_cnt_n  = st_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any && load_s2) begin
          gnt_n     = pick;
          gnt_idx_n = pick_idx;
          mtx_n     = tx_sel;
          st_cnt_n  = ST_LOAD;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (st_cnt_q == '0) state_n  = S_WAIT_LO;
        else                st_cnt_n = st_cnt_q - SW'(1);
      end
      S_WAIT_LO: begin
        if (!load_s2) begin
          state_n = S_WAIT_HI;
        end else if (to_expire) begin
          err_n    = gnt_q;
          gnt_n    = '0;
          rr_ptr_n = ptr_adv;
          state_n  = S_IDLE;
        end
      end
      S_WAIT_HI: begin
        if (load_s2) begin
          rx_n    = mrx_dat;
          done_n  = gnt_q;
          state_n = S_CAPT;
        end else if (to_expire) begin
          err_n    = gnt_q;
          gnt_n    = '0;
          rr_ptr_n = ptr_adv;
          state_n  = S_IDLE;
        end
      end
      S_CAPT: begin
        gnt_n    = '0;
        rr_ptr_n = ptr_adv;
        state_n  = S_IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rx_q      <= '0;
      mtx_q     <= '0;
      st_cnt_q  <= '0;
    end else begin
      state_q   <= state_n;
      gnt_q     <= gnt_n;
      gnt_idx_q <= gnt_idx_n;
      rr_ptr_q  <= rr_ptr_n;
      done_q    <= done_n;
      err_q     <= err_n;
      rx_q      <= rx_n;
      mtx_q     <= mtx_n;
      st_cnt_q  <= st_cnt_n;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rx_dat  = rx_q;
  assign mtx_dat = mtx_q;
  assign busy    = (state_q != S_IDLE);
  assign st      = (state_q == S_START);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter with a behavioural SPI master/slave model.
module tb_spi_txn_arbiter;

  localparam int N = 4;
  localparam int W = 9;
  localparam int ST_LEN = 3;
  localparam int FRAME_LO = 9;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] tx_dat;
  logic [N-1:0]   gnt, done, err;
  logic [W-1:0]   rx_dat, mtx_dat, mrx_dat;
  logic           busy, st, load;

  spi_txn_arbiter #(.N(N), .W(W), .ST_LEN(ST_LEN), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_dat(tx_dat), .gnt(gnt),
    .done(done), .rx_dat(rx_dat), .busy(busy), .err(err), .st(st),
    .mtx_dat(mtx_dat), .load(load), .mrx_dat(mrx_dat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [W-1:0] tx_pl [N];
  logic [W-1:0] slv_rx;
  logic [W-1:0] mst_last;
  logic [W-1:0] stx_next;
  bit           mst_hold;
  bit           mon_en;

  // Master/slave model: on st, slave latches MTX_DAT; master runs a frame
  // with load low, then presents a new MRX_DAT and raises load.
  initial begin
    load     = 1'b1;
    mrx_dat  = '0;
    slv_rx   = '0;
    mst_last = '0;
    stx_next = 9'b111011011;
    forever begin
      @(negedge clk);
      if (st && !mst_hold) begin
        slv_rx = mtx_dat;
        while (st) @(negedge clk);
        repeat (2) @(negedge clk);
        load = 1'b0;
        repeat (FRAME_LO) @(negedge clk);
        mrx_dat  = stx_next;
        mst_last = stx_next;
        stx_next = {stx_next[7:0], stx_next[8]} ^ 9'h055;
        load = 1'b1;
      end
    end
  end

  int st_run = 0;

  // Continuous protocol checks.
  always @(negedge clk) begin
    if (rst) begin
      st_run = 0;
    end else if (mon_en) begin
      if ($countones(gnt) > 1) chk("gnt_onehot", 32'(gnt), 32'(0));
      if (busy !== (gnt != '0)) chk("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
      if (st && gnt == '0) chk("st_without_gnt", 32'(gnt), 32'(1));
`ifndef SPI_ARB_TIMEOUT_EN
      if (err !== '0) chk("err_tied_low", 32'(err), 32'(0));
`endif
      if (st) st_run++;
      else if (st_run != 0) begin
        chk("st_len", 32'(st_run), 32'(ST_LEN));
        st_run = 0;
      end
    end
  end

  typedef struct {
    int           idx;
    logic [W-1:0] pl;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [N-1:0] req;
    int           exp_idx;
  } row_t;
  row_t rows [14];

  task automatic push_exp(input int idx);
    sb_t e;
    e.idx = idx;
    e.pl  = tx_pl[idx];
    sb.push_back(e);
  endtask

  task automatic wait_done(output bit ok);
    int c;
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 300) begin
      @(negedge clk);
      c++;
      if (done != '0) ok = 1'b1;
    end
  endtask

  task automatic finish_frame();
    sb_t          e;
    bit           ok;
    logic [N-1:0] m;
    e = sb.pop_front();
    m = N'(1) << e.idx;
    wait_done(ok);
    chk("done_seen", 32'(ok), 32'(1));
    if (ok) begin
      chk("done_idx", 32'(done), 32'(m));
      chk("gnt_at_done", 32'(gnt), 32'(m));
      chk("rx_dat", 32'(rx_dat), 32'(mst_last));
      chk("slave_rx", 32'(slv_rx), 32'(e.pl));
      chk("mtx_held", 32'(mtx_dat), 32'(e.pl));
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    bit ok;
    int c;
    int extra;

    tx_pl[0] = 9'b101111010;
    tx_pl[1] = 9'h0A5;
    tx_pl[2] = 9'h14C;
    tx_pl[3] = 9'h1F0;
    for (int i = 0; i < N; i++) tx_dat[i*W +: W] = tx_pl[i];

    // rr_ptr is 1 when the table starts (test 1 grants index 0).
    rows[0]  = '{4'b1011, 1};
    rows[1]  = '{4'b1011, 3};
    rows[2]  = '{4'b1011, 0};
    rows[3]  = '{4'b1011, 1};
    rows[4]  = '{4'b1001, 3};
    rows[5]  = '{4'b1001, 0};
    rows[6]  = '{4'b0001, 0};
    rows[7]  = '{4'b0001, 0};
    rows[8]  = '{4'b0110, 1};
    rows[9]  = '{4'b1100, 2};
    rows[10] = '{4'b0110, 1};
    rows[11] = '{4'b1111, 2};
    rows[12] = '{4'b1001, 3};
    rows[13] = '{4'b1001, 0};

    rst      = 1'b1;
    req      = '0;
    mst_hold = 1'b0;
    mon_en   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_st", 32'(st), 32'(0));
    chk("rst_mtx", 32'(mtx_dat), 32'(0));
    chk("rst_rx", 32'(rx_dat), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame, one-cycle grant latency.
    req = 4'b0001;
    push_exp(0);
    @(negedge clk);
    chk("t1_gnt_latency", 32'(gnt), 32'(4'b0001));
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_mtx", 32'(mtx_dat), 32'(9'b101111010));
    finish_frame();
    chk("t1_rx_value", 32'(rx_dat), 32'(9'b111011011));
    chk("t1_slave_value", 32'(slv_rx), 32'(9'b101111010));

    // Table: contention, wrap and continuous requester.
    for (int r = 0; r < 14; r++) begin
      req = rows[r].req;
      push_exp(rows[r].exp_idx);
      finish_frame();
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Reset during WAIT_HI; no grant until load returns high.
    req = 4'b0100;
    c = 0;
    while (gnt !== 4'b0100 && c < 50) begin @(negedge clk); c++; end
    chk("t4_gnt", 32'(gnt), 32'(4'b0100));
    c = 0;
    while (load !== 1'b0 && c < 50) begin @(negedge clk); c++; end
    chk("t4_load_low", 32'(load), 32'(0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4_rst_gnt", 32'(gnt), 32'(0));
    chk("t4_rst_busy", 32'(busy), 32'(0));
    chk("t4_rst_done", 32'(done), 32'(0));
    chk("t4_rst_mtx", 32'(mtx_dat), 32'(0));
    chk("t4_rst_rx", 32'(rx_dat), 32'(0));
    chk("t4_rst_st", 32'(st), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (load === 1'b0 && c < 50) begin
      chk("t4_no_gnt_while_load_low", 32'(gnt), 32'(0));
      chk("t4_no_done", 32'(done), 32'(0));
      @(negedge clk);
      c++;
    end
    push_exp(2);
    finish_frame();
    req = '0;
    repeat (3) @(negedge clk);

    // Request dropped one cycle after grant; frame still completes.
    req = 4'b0100;
    c = 0;
    while (gnt !== 4'b0100 && c < 50) begin @(negedge clk); c++; end
    chk("t6_gnt", 32'(gnt), 32'(4'b0100));
    push_exp(2);
    @(negedge clk);
    req = '0;
    finish_frame();
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done != '0 || gnt != '0) extra++;
    end
    chk("t6_single_done", 32'(extra), 32'(0));

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: master never runs the frame, load stays high.
    mst_hold = 1'b1;
    req = 4'b0001;
    c = 0;
    while (st !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    chk("t5_st_seen", 32'(st), 32'(1));
    c = 0;
    while (st === 1'b1 && c < 50) begin @(negedge clk); c++; end
    c = 0;
    ok = 1'b0;
    while (!ok && c < 40) begin
      @(negedge clk);
      c++;
      if (err != '0) ok = 1'b1;
    end
    req = '0;
    chk("t5_err_delay", 32'(c), 32'(16));
    chk("t5_err_idx", 32'(err), 32'(4'b0001));
    chk("t5_gnt_clear", 32'(gnt), 32'(0));
    chk("t5_no_done", 32'(done), 32'(0));
    @(negedge clk);
    chk("t5_err_one_cycle", 32'(err), 32'(0));
    mst_hold = 1'b0;
    repeat (5) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
